// File: rtl/fetch_stage_if.sv
// Instruction-memory request port between the fetch stage (master) and imem (slave).
// Handshake: a transfer happens on a rising edge where imem_req && imem_ready; imem_rdata is
// valid in that same cycle, and imem_req/imem_addr stay frozen while imem_req && !imem_ready.
interface fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_stage.sv
// IF stage of the RV32I pipeline: owns the PC, fetches over a req/ready port and feeds
// IF/ID with real instructions or NOP bubbles, handling stalls and EX redirects.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall_f,
  input  logic                 pc_src_e,
  input  logic [31:0]          pc_target_e,
  fetch_stage_if.master        imem,
  output logic [31:0]          instruction,
  output logic [31:0]          PCF,
  output logic [31:0]          PCPlus4F,
  output logic                 fetch_valid,
  output logic [1:0]           state_dbg
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    DRAIN = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] drain_addr_q;
  logic [31:0] hold_buf;
  logic [31:0] hold_pc;
  logic [31:0] pc_plus4;
  logic [31:0] hold_pc_plus4;
  logic [31:0] target_aligned;
  logic        unused_target_bits;

  assign pc_plus4           = pc_q + 32'd4;
  assign hold_pc_plus4      = hold_pc + 32'd4;
  assign target_aligned     = {pc_target_e[31:2], 2'b00};
  assign unused_target_bits = ^pc_target_e[1:0];

  // Request is gated by rst so an in-flight access is abandoned the moment reset asserts.
  assign imem.imem_req  = (state_q != HOLD) && !rst;
  assign imem.imem_addr = (state_q == DRAIN) ? drain_addr_q : pc_q;
  assign state_dbg      = state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      drain_addr_q <= 32'h0;
      hold_buf     <= NOP_INSTR;
      hold_pc      <= 32'h0;
      instruction  <= NOP_INSTR;
      PCF          <= 32'h0;
      PCPlus4F     <= 32'h0;
      fetch_valid  <= 1'b0;
    end else if (pc_src_e) begin
      instruction <= NOP_INSTR;
      fetch_valid <= 1'b0;
      pc_q        <= target_aligned;
      // A pending request cannot be withdrawn, so its address is parked and drained first.
      case (state_q)
        FETCH: begin
          if (!imem.imem_ready) begin
            drain_addr_q <= pc_q;
            state_q      <= DRAIN;
          end
        end
        DRAIN: begin
          if (imem.imem_ready) state_q <= FETCH;
        end
        default: state_q <= FETCH;
      endcase
    end else if (stall_f) begin
      case (state_q)
        FETCH: begin
          if (imem.imem_ready) begin
            hold_buf <= imem.imem_rdata;
            hold_pc  <= pc_q;
            pc_q     <= pc_plus4;
            state_q  <= HOLD;
          end
        end
        DRAIN: begin
          if (imem.imem_ready) state_q <= FETCH;
        end
        default: state_q <= state_q;
      endcase
    end else begin
      case (state_q)
        FETCH: begin
          if (imem.imem_ready) begin
            instruction <= imem.imem_rdata;
            PCF         <= pc_q;
            PCPlus4F    <= pc_plus4;
            fetch_valid <= 1'b1;
            pc_q        <= pc_plus4;
          end else begin
            instruction <= NOP_INSTR;
            fetch_valid <= 1'b0;
          end
        end
        HOLD: begin
          instruction <= hold_buf;
          PCF         <= hold_pc;
          PCPlus4F    <= hold_pc_plus4;
          fetch_valid <= 1'b1;
          state_q     <= FETCH;
        end
        DRAIN: begin
          instruction <= NOP_INSTR;
          fetch_valid <= 1'b0;
          if (imem.imem_ready) state_q <= FETCH;
        end
        default: state_q <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios followed by random ready/stall/redirect traffic,
// checked against a program-order model of which PC must be delivered next.
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        stall_f;
  logic        pc_src_e;
  logic [31:0] pc_target_e;
  logic [31:0] instruction;
  logic [31:0] PCF;
  logic [31:0] PCPlus4F;
  logic        fetch_valid;
  logic [1:0]  state_dbg;

  fetch_stage_if imem ();

  int vectors;
  int miscompares;
  int idle;
  logic [31:0] exp_q[$];

  fetch_stage #(
    .RESET_PC  (RESET_PC),
    .NOP_INSTR (NOP_INSTR)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .stall_f     (stall_f),
    .pc_src_e    (pc_src_e),
    .pc_target_e (pc_target_e),
    .imem        (imem.master),
    .instruction (instruction),
    .PCF         (PCF),
    .PCPlus4F    (PCPlus4F),
    .fetch_valid (fetch_valid),
    .state_dbg   (state_dbg)
  );

  // Memory contents are a fixed function of the address, so any word can be predicted.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_0000;
  endfunction

  assign imem.imem_rdata = mem_word(imem.imem_addr);

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    stall_f     = 1'b0;
    pc_src_e    = 1'b0;
    pc_target_e = 32'h0;
    rst         = 1'b1;
    #1;
    check("rst_instr", instruction, NOP_INSTR);
    check("rst_pcf", PCF, 32'h0);
    check("rst_pcplus4", PCPlus4F, 32'h0);
    check("rst_valid", 32'(fetch_valid), 32'h0);
    check("rst_req", 32'(imem.imem_req), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    exp_q.push_back(RESET_PC);
    idle = 0;
  endtask

  // One clock: drive inputs, record pre-edge view, then score the post-edge outputs.
  task automatic cycle(input logic r, input logic s, input logic p, input logic [31:0] t);
    logic        p_req;
    logic [31:0] p_addr;
    logic [96:0] p_out;
    logic [31:0] e;
    imem.imem_ready = r;
    stall_f         = s;
    pc_src_e        = p;
    pc_target_e     = t;
    #1;
    p_req  = imem.imem_req;
    p_addr = imem.imem_addr;
    p_out  = {instruction, PCF, PCPlus4F, fetch_valid};
    @(posedge clk);
    #1;
    if (p_req && !r) begin
      check("req_held", 32'(imem.imem_req), 32'h1);
      check("addr_stable", imem.imem_addr, p_addr);
    end
    if (p) begin
      check("redir_bubble", 32'(fetch_valid), 32'h0);
      check("redir_nop", instruction, NOP_INSTR);
      exp_q.delete();
      exp_q.push_back({t[31:2], 2'b00});
      idle = 0;
    end else if (s) begin
      check("stall_valid", 32'(fetch_valid), 32'(p_out[0]));
      check("stall_instr", instruction, p_out[96:65]);
      check("stall_pcf", PCF, p_out[64:33]);
      check("stall_pcplus4", PCPlus4F, p_out[32:1]);
    end else if (fetch_valid) begin
      e = exp_q.pop_front();
      check("pcf", PCF, e);
      check("pcplus4", PCPlus4F, e + 32'd4);
      check("instr", instruction, mem_word(e));
      exp_q.push_back(e + 32'd4);
      idle = 0;
    end else begin
      check("bubble_nop", instruction, NOP_INSTR);
      if (r) begin
        idle++;
        if (idle > 2) begin
          check("liveness", 32'(idle), 32'd2);
          idle = 0;
        end
      end
    end
  endtask

  initial begin
    logic [31:0] t;
    vectors         = 0;
    miscompares     = 0;
    idle            = 0;
    imem.imem_ready = 1'b1;
    do_reset();

    // zero-wait memory: one instruction per cycle from RESET_PC
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 32'h0);
      check("zw_valid", 32'(fetch_valid), 32'h1);
      check("zw_pcf", PCF, 32'(i * 4));
    end

    // two-cycle memory: a bubble precedes every word
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 32'h0);
      check("lat2_bubble", 32'(fetch_valid), 32'h0);
      cycle(1'b1, 1'b0, 1'b0, 32'h0);
      check("lat2_valid", 32'(fetch_valid), 32'h1);
      check("lat2_pcf", PCF, 32'h0C + 32'(i * 4));
    end

    // stall for three cycles while the word at 0x8 returns
    do_reset();
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 32'h0);
      check("stall_frozen_pcf", PCF, 32'h4);
      check("stall_req_low", 32'(imem.imem_req), 32'h0);
    end
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    check("unstall_pcf8", PCF, 32'h8);
    check("unstall_valid", 32'(fetch_valid), 32'h1);
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    check("unstall_pcfc", PCF, 32'hC);

    // redirect to 0x100 while the 0x10 request is still waiting
    cycle(1'b0, 1'b0, 1'b0, 32'h0);
    check("pend_addr", imem.imem_addr, 32'h10);
    cycle(1'b0, 1'b0, 1'b1, 32'h100);
    check("drain_addr", imem.imem_addr, 32'h10);
    cycle(1'b0, 1'b0, 1'b0, 32'h0);
    check("drain_addr2", imem.imem_addr, 32'h10);
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    check("drain_done_bubble", 32'(fetch_valid), 32'h0);
    check("post_drain_addr", imem.imem_addr, 32'h100);
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    check("target_pcf", PCF, 32'h100);
    check("target_valid", 32'(fetch_valid), 32'h1);

    // redirect while a stalled word is parked, target low bits ignored
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    check("hold_req_low", 32'(imem.imem_req), 32'h0);
    cycle(1'b1, 1'b1, 1'b1, 32'h203);
    check("hold_redir_addr", imem.imem_addr, 32'h200);
    check("hold_redir_req", 32'(imem.imem_req), 32'h1);
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    check("aligned_pcf", PCF, 32'h200);
    check("aligned_valid", 32'(fetch_valid), 32'h1);

    // PC wraps at the top of the address space
    cycle(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    check("wrap_pcf", PCF, 32'hFFFF_FFFC);
    check("wrap_pcplus4", PCPlus4F, 32'h0);
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    check("wrap_next_pcf", PCF, 32'h0);
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 1'b0, 32'h0);
    check("midwait_req", 32'(imem.imem_req), 32'h1);
    do_reset();
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    check("after_rst_pcf", PCF, RESET_PC);
    check("after_rst_valid", 32'(fetch_valid), 32'h1);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      t = $urandom;
      if ($urandom_range(0, 3) == 0) t = 32'hFFFF_FFF0 | (t & 32'hF);
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
            $urandom_range(0, 15) == 0, t);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
